// File: rtl/multicycle_cpu_core.sv
// multicycle_cpu_core: FETCH/DECODE/EXECUTE/MEM/WRITEBACK multi-cycle core
// with internal register file, 8-op ISA and req/ack instruction/data ports.
// Ports: clk, rst (sync, active-high); imem_req/addr/ack/rdata instruction
// fetch; dmem_req/we/addr/wdata/ack/rdata data access; pc_out, halted.
// Optional CPU_PERF_CNT_EN adds retired_cnt and cycle_cnt outputs.
module multicycle_cpu_core #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 16,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [15:0]       dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]   pc_out,
  output logic              halted
`ifdef CPU_PERF_CNT_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       cycle_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_LD   = 3'd0;
  localparam logic [2:0] OP_ST   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  state_t            state;
  state_t            state_nx;
  logic [31:0]       instr;
  logic [2:0]        op;
  logic [4:0]        a0;
  logic [15:0]       addr;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] va0;
  logic [DATA_W-1:0] va1;
  logic [DATA_W-1:0] va2;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] rf_a0;
  logic [DATA_W-1:0] rf_a1;
  logic [DATA_W-1:0] rf_a2;
  logic [DATA_W-1:0] regs [NREGS];

  // R0 and indices past the implemented file are hard zero / write-dropped
  function automatic logic rf_hit(input logic [4:0] idx);
    return (idx != 5'd0) && (int'(idx) < NREGS);
  endfunction

  assign imem_req  = (state == S_FETCH) && !rst;
  assign dmem_req  = (state == S_MEM);
  assign halted    = (state == S_HALT);
  assign imem_addr = pc;
  assign pc_out    = pc;

  always_comb begin
    rf_a0 = '0;
    rf_a1 = '0;
    rf_a2 = '0;
    if (rf_hit(instr[28:24])) rf_a0 = regs[instr[28:24]];
    if (rf_hit(instr[23:19])) rf_a1 = regs[instr[23:19]];
    if (rf_hit(instr[18:14])) rf_a2 = regs[instr[18:14]];
  end

  always_comb begin
    alu_y = '0;
    unique case (1'b1)
      op == OP_ADD: alu_y = va1 + va2;
      op == OP_SUB: alu_y = va1 - va2;
      op == OP_AND: alu_y = va1 & va2;
      op == OP_OR:  alu_y = va1 | va2;
      default:      alu_y = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH:  if (imem_ack) state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          op == OP_LD,
          op == OP_ST:   state_nx = S_MEM;
          op == OP_BEQ:  state_nx = S_FETCH;
          op == OP_HALT: state_nx = S_HALT;
          default:       state_nx = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ack)
          state_nx = (op == OP_LD) ? S_WB : S_FETCH;
      end
      S_WB:     state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      instr      <= '0;
      op         <= '0;
      a0         <= '0;
      addr       <= '0;
      va0        <= '0;
      va1        <= '0;
      va2        <= '0;
      result     <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (imem_ack) begin
            instr <= imem_rdata;
            pc    <= pc + 1'b1;
          end
        end
        S_DECODE: begin
          op   <= instr[31:29];
          a0   <= instr[28:24];
          addr <= instr[15:0];
          va0  <= rf_a0;
          va1  <= rf_a1;
          va2  <= rf_a2;
        end
        S_EXEC: begin
          result <= alu_y;
          if (op == OP_BEQ && va1 == va2)
            pc <= addr[PC_W-1:0];
          // data bus is loaded once here so it is stable for all of MEM
          if (op == OP_LD || op == OP_ST) begin
            dmem_we    <= (op == OP_ST);
            dmem_addr  <= addr;
            dmem_wdata <= va0;
          end
        end
        S_MEM: begin
          if (dmem_ack && op == OP_LD)
            result <= dmem_rdata;
        end
        S_WB: begin
          if (rf_hit(a0)) regs[a0] <= result;
        end
        default: ;
      endcase
    end
  end

`ifdef CPU_PERF_CNT_EN
  logic retire;

  always_comb begin
    retire = (state == S_WB)
          || (state == S_MEM && dmem_ack && op == OP_ST)
          || (state == S_EXEC && (op == OP_BEQ || op == OP_HALT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= '0;
      cycle_cnt   <= '0;
    end else begin
      if (!halted) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire)  retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule
